// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, control strobes from the
// multicycle control unit, and the fetch-stage outputs consumed downstream.
interface fetch_unit_if #(
    parameter int AddrWidth = 10,
    parameter int CntWidth  = 16
);
    // Instruction memory
    logic [AddrWidth-1:0] im_addr;
    logic [31:0]          im_dout;

    // Control strobes and next-PC operands
    logic                 pc_wr;
    logic                 ir_wr;
    logic [1:0]           npc_op;
    logic                 br_taken;
    logic [31:0]          rs_data;

    // Fetch-stage state visible to the rest of the datapath
    logic [31:0]          pc;
    logic [31:0]          ir;
    logic [31:0]          ir_pc;
    logic                 instr_valid;
    logic                 fault;
    logic [CntWidth-1:0]  fetch_cnt;

    // Control unit / memory / datapath side
    modport master (
        input  im_addr,
        output im_dout,
        output pc_wr,
        output ir_wr,
        output npc_op,
        output br_taken,
        output rs_data,
        input  pc,
        input  ir,
        input  ir_pc,
        input  instr_valid,
        input  fault,
        input  fetch_cnt
    );

    // Fetch unit side
    modport slave (
        output im_addr,
        input  im_dout,
        input  pc_wr,
        input  ir_wr,
        input  npc_op,
        input  br_taken,
        input  rs_data,
        output pc,
        output ir,
        output ir_pc,
        output instr_valid,
        output fault,
        output fetch_cnt
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage of a multicycle MIPS datapath. Owns the PC and the
// instruction register, selects the next PC (sequential, branch, jump, jr)
// and traps on misaligned or out-of-range fetch targets with a sticky fault.
module fetch_unit #(
    parameter int          AddrWidth = 10,
    parameter logic [31:0] ResetPC   = 32'h0000_0000,
    parameter int          CntWidth  = 16
) (
    input logic         clk,
    input logic         rst,
    fetch_unit_if.slave bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_VALID = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        NPC_SEQ    = 2'b00,
        NPC_BRANCH = 2'b01,
        NPC_JUMP   = 2'b10,
        NPC_JR     = 2'b11
    } npc_op_e;

    state_e               state_q, state_d;
    logic [31:0]          pc_q, pc_d;
    logic [31:0]          ir_q, ir_d;
    logic [31:0]          ir_pc_q, ir_pc_d;
    logic [CntWidth-1:0]  fetch_cnt_q, fetch_cnt_d;
    logic                 instr_valid_q, instr_valid_d;
    logic                 fault_q, fault_d;

    logic [31:0]          pc_plus4;
    logic [31:0]          ir_pc_plus4;
    logic [31:0]          br_offset;
    logic [31:0]          target;
    logic                 target_legal;
    logic                 pc_update_req;

    // Next-PC candidates, always formed from the registered ir/ir_pc so a
    // simultaneous IR load never affects the target chosen on that edge.
    always_comb begin
        pc_plus4    = pc_q + 32'd4;
        ir_pc_plus4 = ir_pc_q + 32'd4;
        br_offset   = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

        unique case (npc_op_e'(bus.npc_op))
            NPC_SEQ:    target = pc_plus4;
            NPC_BRANCH: target = ir_pc_plus4 + br_offset;
            NPC_JUMP:   target = {ir_pc_plus4[31:28], ir_q[25:0], 2'b00};
            NPC_JR:     target = bus.rs_data;
            default:    target = pc_plus4;
        endcase

        // Word-aligned and inside the instruction memory's byte range.
        target_legal = (target[1:0] == 2'b00) && (target[31:AddrWidth+2] == '0);

        // An untaken branch is not a PC write at all: no update and no check.
        pc_update_req = bus.pc_wr &&
                        !((npc_op_e'(bus.npc_op) == NPC_BRANCH) && !bus.br_taken);
    end

    // Next-state logic for the FSM, PC, IR and fetch counter.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        ir_pc_d     = ir_pc_q;
        fetch_cnt_d = fetch_cnt_q;

        if (state_q != ST_FAULT) begin
            if (bus.ir_wr) begin
                ir_d        = bus.im_dout;
                ir_pc_d     = pc_q;
                fetch_cnt_d = fetch_cnt_q + CntWidth'(1);
                state_d     = ST_VALID;
            end

            if (pc_update_req) begin
                if (target_legal) begin
                    pc_d = target;
                end else begin
                    state_d = ST_FAULT;
                end
            end
        end

        // Status outputs are registered decodes of the next state.
        instr_valid_d = (state_d == ST_VALID);
        fault_d       = (state_d == ST_FAULT);
    end

    // State register with synchronous reset taking priority over all strobes.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q       <= ST_EMPTY;
            pc_q          <= ResetPC;
            ir_q          <= '0;
            ir_pc_q       <= '0;
            fetch_cnt_q   <= '0;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            ir_pc_q       <= ir_pc_d;
            fetch_cnt_q   <= fetch_cnt_d;
            instr_valid_q <= instr_valid_d;
            fault_q       <= fault_d;
        end
    end

    assign bus.im_addr     = pc_q[AddrWidth+1:2];
    assign bus.pc          = pc_q;
    assign bus.ir          = ir_q;
    assign bus.ir_pc       = ir_pc_q;
    assign bus.fetch_cnt   = fetch_cnt_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.fault       = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed stimulus, a spec-level reference model
// compared on every falling edge, plus literal expectations at key points.
module tb_fetch_unit;

    localparam int AW = 10;
    localparam int CW = 16;

    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    logic [31:0] mem [1024];

    fetch_unit_if #(.AddrWidth(AW), .CntWidth(CW)) bus ();

    fetch_unit #(
        .AddrWidth(AW),
        .ResetPC  (32'h0000_0000),
        .CntWidth (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Combinational-read instruction memory.
    assign bus.im_dout = mem[bus.im_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural state of the fetch stage.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] ir_pc;
        logic        valid;
        logic        fault;
        logic [15:0] cnt;
    } model_t;

    model_t m;

    function automatic model_t next_model(model_t cur, logic r, logic pw, logic iw,
                                          logic [1:0] op, logic bt, logic [31:0] rs);
        model_t      n;
        logic [31:0] tgt;
        logic [31:0] seq_of_ir;
        int          off;
        n = cur;
        if (r) begin
            n.pc = 32'h0; n.ir = 32'h0; n.ir_pc = 32'h0;
            n.valid = 1'b0; n.fault = 1'b0; n.cnt = 16'h0;
            return n;
        end
        if (cur.fault) return n;
        if (iw) begin
            n.ir    = mem[cur.pc[11:2]];
            n.ir_pc = cur.pc;
            n.cnt   = cur.cnt + 16'd1;
            n.valid = 1'b1;
        end
        seq_of_ir = cur.ir_pc + 32'd4;
        off       = int'($signed(cur.ir[15:0]));
        case (op)
            2'b00:   tgt = cur.pc + 32'd4;
            2'b01:   tgt = seq_of_ir + 32'(off * 4);
            2'b10:   tgt = {seq_of_ir[31:28], cur.ir[25:0], 2'b00};
            default: tgt = rs;
        endcase
        if (pw && !(op == 2'b01 && !bt)) begin
            if ((tgt % 4 == 0) && (tgt < 32'h1000)) begin
                n.pc = tgt;
            end else begin
                n.fault = 1'b1;
                n.valid = 1'b0;
            end
        end
        return n;
    endfunction

    always @(posedge clk)
        m <= next_model(m, rst, bus.pc_wr, bus.ir_wr, bus.npc_op, bus.br_taken, bus.rs_data);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_pc",          bus.pc,                   m.pc);
            check("model_im_addr",     32'(bus.im_addr),         32'(m.pc[11:2]));
            check("model_ir",          bus.ir,                   m.ir);
            check("model_ir_pc",       bus.ir_pc,                m.ir_pc);
            check("model_instr_valid", 32'(bus.instr_valid),     32'(m.valid));
            check("model_fault",       32'(bus.fault),           32'(m.fault));
            check("model_fetch_cnt",   32'(bus.fetch_cnt),       32'(m.cnt));
        end
    end

    task automatic step(input logic r, input logic pw, input logic iw,
                        input logic [1:0] op, input logic bt, input logic [31:0] rs);
        rst          = r;
        bus.pc_wr    = pw;
        bus.ir_wr    = iw;
        bus.npc_op   = op;
        bus.br_taken = bt;
        bus.rs_data  = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0]  = 32'h2008_0005;
        mem[1]  = 32'h2009_0007;
        mem[2]  = 32'h0000_0020;
        mem[3]  = 32'h0123_4567;
        mem[4]  = 32'h1000_FFFE;
        mem[8]  = 32'h0800_0040;
        mem[64] = 32'h1000_0003;

        rst = 1'b1;
        bus.pc_wr = 1'b0; bus.ir_wr = 1'b0; bus.npc_op = 2'b00;
        bus.br_taken = 1'b0; bus.rs_data = 32'h0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
        cmp_en = 1'b1;
        check("rst_pc", bus.pc, 32'h0);
        check("rst_valid", 32'(bus.instr_valid), 32'h0);
        check("rst_cnt", 32'(bus.fetch_cnt), 32'h0);

        // Two canonical fetch cycles
        step(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0);
        check("fetch2_ir", bus.ir, 32'h2009_0007);
        check("fetch2_ir_pc", bus.ir_pc, 32'h4);
        check("fetch2_pc", bus.pc, 32'h8);
        check("fetch2_cnt", 32'(bus.fetch_cnt), 32'd2);
        check("fetch2_valid", 32'(bus.instr_valid), 32'h1);

        // Walk to 0x10 and fetch the branch word
        step(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0);
        check("br_ir", bus.ir, 32'h1000_FFFE);
        check("br_ir_pc", bus.ir_pc, 32'h10);

        // Taken branch: 0x10 + 4 - 8 = 0x0C
        step(1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 32'h0);
        check("br_taken_pc", bus.pc, 32'h0C);
        // Untaken branch: pc holds
        step(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 32'hFFFF_FFFF);
        check("br_untaken_pc", bus.pc, 32'h0C);
        check("br_untaken_fault", 32'(bus.fault), 32'h0);

        // jr to 0x20, fetch the jump word without advancing, then jump
        step(1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 32'h20);
        check("jr_pc", bus.pc, 32'h20);
        step(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0);
        check("j_ir", bus.ir, 32'h0800_0040);
        check("j_ir_pc", bus.ir_pc, 32'h20);
        step(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0);
        check("j_pc", bus.pc, 32'h100);

        // Simultaneous load and branch: target from old ir (0x40 words) at old ir_pc 0x20
        step(1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 32'h0);
        check("sim_pc", bus.pc, 32'h124);
        check("sim_ir", bus.ir, 32'h1000_0003);
        check("sim_ir_pc", bus.ir_pc, 32'h100);
        check("sim_cnt", 32'(bus.fetch_cnt), 32'd7);

        // Misaligned jr target -> fault, pc holds
        step(1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0102);
        check("mis_fault", 32'(bus.fault), 32'h1);
        check("mis_valid", 32'(bus.instr_valid), 32'h0);
        check("mis_pc", bus.pc, 32'h124);
        // Strobes ignored while faulted
        step(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 32'h40);
        check("frz_pc", bus.pc, 32'h124);
        check("frz_ir", bus.ir, 32'h1000_0003);
        check("frz_cnt", 32'(bus.fetch_cnt), 32'd7);
        check("frz_fault", 32'(bus.fault), 32'h1);
        // Reset leaves fault
        step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
        check("unfault_pc", bus.pc, 32'h0);
        check("unfault_fault", 32'(bus.fault), 32'h0);

        // Out-of-range jr target from EMPTY
        step(1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_1000);
        check("oor_fault", 32'(bus.fault), 32'h1);
        check("oor_pc", bus.pc, 32'h0);
        // Highest legal word is accepted
        step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0FFC);
        check("edge_pc", bus.pc, 32'h0FFC);
        check("edge_fault", 32'(bus.fault), 32'h0);
        // Sequential step past the top faults
        step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0);
        check("top_fault", 32'(bus.fault), 32'h1);
        check("top_pc", bus.pc, 32'h0FFC);

        // Counter wrap
        step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
        for (int i = 0; i < 65535; i++) step(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0);
        check("cnt_max", 32'(bus.fetch_cnt), 32'h0000_FFFF);
        step(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0);
        check("cnt_wrap", 32'(bus.fetch_cnt), 32'h0);
        check("cnt_wrap_valid", 32'(bus.instr_valid), 32'h1);

        // Reset has priority over simultaneous strobes
        step(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0);
        check("rstpri_pc", bus.pc, 32'h0);
        check("rstpri_ir", bus.ir, 32'h0);
        check("rstpri_ir_pc", bus.ir_pc, 32'h0);
        check("rstpri_valid", 32'(bus.instr_valid), 32'h0);
        check("rstpri_fault", 32'(bus.fault), 32'h0);
        check("rstpri_cnt", 32'(bus.fetch_cnt), 32'h0);

        idle();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
